aim_motor_ctrl: RTL
===================

Name: aim_motor_ctrl

Overview:
Pan/tilt stepper sequencer driven by the red-target tracker outputs. Once per video frame it converts the target's pixel error from screen centre into bounded step jobs for two stepper axes. It also runs a pan search sweep when the target is lost, and gates the laser only once the aim is stable. It sits between the tracker (aim_x/aim_y/aim_detected/target_off/raser_shoot) and the motor-driver pins.

Parameters:
CENTER_X, 320, screen-centre column (pixels)
CENTER_Y, 240, screen-centre row (pixels)
DEADBAND, 16, |error| at or below this → no motion on that axis
GAIN_SHIFT, 2, steps = |error| >> GAIN_SHIFT
MAX_STEPS, 32, per-frame step cap per axis
STEP_HALF, 25000, clk cycles per low and per high phase of a step pulse
LOCK_FRAMES, 4, consecutive in-deadband frames required to lock
PAN_LIMIT, 400, soft limit on net pan position, in ±steps

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse at the vsync rising edge
aim_x  in  10  target centre column
aim_y  in  10  target centre row
aim_detected  in  1  target present this frame
target_off  in  1  target absent for ≥3 s
raser_shoot  in  1  tracker reports aim inside the fire window
pan_step, pan_dir  out  1, 1  pan driver STEP/DIR
tilt_step, tilt_dir  out  1, 1  tilt driver STEP/DIR
laser_en  out  1  laser fire enable
state_o  out  2  current FSM state (debug)
pan_pos  out  12  signed net pan steps issued (debug)

Behaviour:
- Reset (async): all outputs 0, FSM=IDLE, lock counter 0, pan_pos 0, step generators idle.
  - Reset mid-pulse drives pan_step/tilt_step low immediately.
- Error computation, per axis:
  - ex = {1'b0,aim_x} − CENTER_X as 11-bit signed; ey likewise.
  - mag = |e|; dir = 1 when e > 0.
  - steps = 0 if mag ≤ DEADBAND, else min(mag >> GAIN_SHIFT, MAX_STEPS).
- FSM, evaluated only on frame_tick; encoding IDLE=0, TRACK=1, LOCKED=2, SEARCH=3.
  - IDLE → TRACK if aim_detected, else → SEARCH.
  - TRACK: if target_off → SEARCH (lock cnt cleared).
    - Otherwise, if aim_detected: load both axis jobs. If both steps=0, increment lock cnt, else clear it.
    - Lock cnt reaching LOCK_FRAMES → LOCKED.
    - aim_detected=0 with target_off=0: no load, hold state.
  - LOCKED: target_off → SEARCH. aim_detected with either steps≠0 → TRACK (jobs loaded, lock cnt cleared). Otherwise hold, no motion.
  - SEARCH: aim_detected → TRACK (jobs loaded).
    - Otherwise load a pan job of MAX_STEPS in the sweep direction; tilt idle.
    - Sweep dir flips when pan_pos reaches +PAN_LIMIT or −PAN_LIMIT.
- laser_en (registered): (state==LOCKED) && raser_shoot. Deasserts the cycle after leaving LOCKED.
- Step generator, per axis:
  - Each step is STEP_HALF cycles low, then STEP_HALF cycles high.
  - Remaining count decrements, and pan_pos updates ±1, at the end of the high phase.
  - dir updates only at load, while step is low, so setup time is ≥ STEP_HALF.
  - A load arriving while a step is in progress is held pending and applied at the end of the current high phase. The pulse is never truncated, and a pending load replaces any earlier pending load.
  - A load with count 0 stops the axis after the current pulse.
- Pan soft limit: a step that would move pan_pos beyond ±PAN_LIMIT is not started; the remaining count is cleared.
- frame_tick coinciding with a step completion: the completion is applied first, then the load is accepted (becomes active immediately).

Decomposition:
- Package aim_ctrl_pkg: state enum (IDLE/TRACK/LOCKED/SEARCH), axis error/steps widths, and a step-job struct {count[5:0], dir}.
- Sub-module step_pulse_gen (parameter STEP_HALF): load/count/dir in, pending register, step/dir/busy/step_done out. Instantiated once per axis.

Test Plan (bench STEP_HALF=4):
- Reset, then frame_tick with aim_detected=1, aim_x=400, aim_y=240 → TRACK. pan_dir=1 with 20 pan_step rising edges, 8-cycle period, first rise 4 cycles after load. tilt silent; pan_pos=20.
- aim_x=0, aim_y=479 → pan 32 steps with dir=0 (capped), tilt 32 steps with dir=1.
- aim_x=330, aim_y=235 held for 4 frames → state_o=2 on the 4th tick. raser_shoot=1 → laser_en=1 one cycle later. Then aim_x=400 → TRACK and laser_en=0.
- target_off=1 → SEARCH with MAX_STEPS pan jobs per frame. pan_dir flips when pan_pos reaches +400, and again at −400.
- frame_tick mid-pulse with a new job → current pulse completes full width, new count/dir take effect after its high phase; no step glitch.
- Assert reset during a high phase → pan_step=0 asynchronously, state_o=0, pan_pos=0.

Source files
------------

// File: rtl/aim_ctrl_pkg.sv
// Shared types for the pan/tilt aim controller.
//   aim_state_e : controller FSM states (encoding is visible on state_o)
//   step_job_t  : one per-axis step job (step count + direction)
//   calc_job    : pixel coordinate -> bounded step job for one axis
package aim_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StTrack  = 2'd1,
    StLocked = 2'd2,
    StSearch = 2'd3
  } aim_state_e;

  localparam int unsigned PixW  = 10;  // tracker coordinate width
  localparam int unsigned ErrW  = 11;  // signed pixel error width
  localparam int unsigned StepW = 6;   // job step count width

  typedef struct packed {
    logic [StepW-1:0] count;
    logic             dir;
  } step_job_t;

  // Error from centre, deadband, gain shift and cap for one axis.
  function automatic step_job_t calc_job(input logic [PixW-1:0] pix,
                                         input int unsigned     center,
                                         input int unsigned     deadband,
                                         input int unsigned     gain_shift,
                                         input int unsigned     max_steps);
    logic [ErrW-1:0] err;
    logic [ErrW-1:0] mag;
    logic [ErrW-1:0] shifted;
    step_job_t       job;
    err       = {1'b0, pix} - ErrW'(center);
    mag       = err[ErrW-1] ? (~err + ErrW'(1)) : err;
    shifted   = mag >> gain_shift;
    job.dir   = !err[ErrW-1] && (err != '0);
    if (mag <= ErrW'(deadband)) begin
      job.count = '0;
    end else if (shifted > ErrW'(max_steps)) begin
      job.count = StepW'(max_steps);
    end else begin
      job.count = StepW'(shifted);
    end
    return job;
  endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for one stepper axis.
// Each step is STEP_HALF cycles low followed by STEP_HALF cycles high. A load
// that arrives mid-job is parked in a pending slot (latest wins) and taken at
// the end of the current high phase, so a pulse is never cut short and dir
// only changes while step is low.
// Ports:
//   clk, reset            clock, async active-high reset
//   load                  accept a new job (load_count, load_dir)
//   block_pos, block_neg  refuse to raise a step in that direction
//   step, dir             driver STEP/DIR pins (registered)
//   busy                  a job is in progress
//   step_done             one-cycle pulse at the end of each high phase
module step_pulse_gen
  import aim_ctrl_pkg::*;
#(
  parameter int unsigned STEP_HALF = 25000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [StepW-1:0] load_count,
  input  logic             load_dir,
  input  logic             block_pos,
  input  logic             block_neg,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             step_done
);

  localparam int unsigned TimerW = (STEP_HALF > 1) ? $clog2(STEP_HALF) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(STEP_HALF - 1);

  logic              busy_q, busy_d, step_q, step_d, dir_q, dir_d;
  logic [StepW-1:0]  cnt_q, cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              pend_valid_q, pend_valid_d, pend_dir_q, pend_dir_d;
  logic [StepW-1:0]  pend_count_q, pend_count_d;

  logic phase_end, rise, done, blocked, accept_now;

  assign phase_end  = busy_q && (timer_q == TimerLast);
  assign rise       = phase_end && !step_q;
  assign done       = phase_end && step_q;
  // Checked at the rising edge so the limit sees the position after the last step.
  assign blocked    = rise && (dir_q ? block_pos : block_neg);
  assign accept_now = !busy_q || done || blocked;

  always_comb begin
    busy_d       = busy_q;
    step_d       = step_q;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    pend_valid_d = pend_valid_q;
    pend_count_d = pend_count_q;
    pend_dir_d   = pend_dir_q;

    if (busy_q) timer_d = phase_end ? '0 : timer_q + TimerW'(1);

    if (blocked) begin
      busy_d       = 1'b0;
      cnt_d        = '0;
      pend_valid_d = 1'b0;
    end else if (rise) begin
      step_d = 1'b1;
    end

    if (done) begin
      step_d = 1'b0;
      cnt_d  = cnt_q - StepW'(1);
      busy_d = (cnt_q != StepW'(1));
    end

    // A direct load outranks the pending slot; both start a fresh low phase.
    if (load && accept_now) begin
      cnt_d        = load_count;
      dir_d        = load_dir;
      busy_d       = (load_count != '0);
      timer_d      = '0;
      step_d       = 1'b0;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_valid_d = 1'b1;
      pend_count_d = load_count;
      pend_dir_d   = load_dir;
    end else if (done && pend_valid_q) begin
      cnt_d        = pend_count_q;
      dir_d        = pend_dir_q;
      busy_d       = (pend_count_q != '0);
      timer_d      = '0;
      step_d       = 1'b0;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= 1'b0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      cnt_q        <= '0;
      timer_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_count_q <= '0;
      pend_dir_q   <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      pend_valid_q <= pend_valid_d;
      pend_count_q <= pend_count_d;
      pend_dir_q   <= pend_dir_d;
    end
  end

  assign step      = step_q;
  assign dir       = dir_q;
  assign busy      = busy_q;
  assign step_done = done;

endmodule

// File: rtl/aim_motor_ctrl.sv
// Pan/tilt stepper sequencer fed by the red-target tracker. Once per frame it
// turns the target's pixel error into bounded step jobs, sweeps pan when the
// target is lost, and enables the laser only while locked on.
// Ports:
//   clk, reset                     clock, async active-high reset
//   frame_tick                     one-cycle pulse per video frame
//   aim_x, aim_y                   target centre (pixels)
//   aim_detected, target_off       target present / lost for a long time
//   raser_shoot                    tracker says aim is inside the fire window
//   pan_step, pan_dir              pan driver STEP/DIR
//   tilt_step, tilt_dir            tilt driver STEP/DIR
//   laser_en                       laser fire enable
//   state_o                        FSM state (debug)
//   pan_pos                        signed net pan steps issued (debug)
module aim_motor_ctrl
  import aim_ctrl_pkg::*;
#(
  parameter int unsigned CENTER_X    = 320,
  parameter int unsigned CENTER_Y    = 240,
  parameter int unsigned DEADBAND    = 16,
  parameter int unsigned GAIN_SHIFT  = 2,
  parameter int unsigned MAX_STEPS   = 32,
  parameter int unsigned STEP_HALF   = 25000,
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned PAN_LIMIT   = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [9:0]  aim_x,
  input  logic [9:0]  aim_y,
  input  logic        aim_detected,
  input  logic        target_off,
  input  logic        raser_shoot,
  output logic        pan_step,
  output logic        pan_dir,
  output logic        tilt_step,
  output logic        tilt_dir,
  output logic        laser_en,
  output logic [1:0]  state_o,
  output logic [11:0] pan_pos
);

  localparam int unsigned LockW = $clog2(LOCK_FRAMES + 1);
  localparam logic [LockW-1:0] LockLast = LockW'(LOCK_FRAMES - 1);
  localparam int PanLimI = int'(PAN_LIMIT);
  localparam logic signed [11:0] PanLimPos = 12'(PanLimI);
  localparam logic signed [11:0] PanLimNeg = 12'(-PanLimI);

  aim_state_e       state_q;
  logic [LockW-1:0] lock_cnt_q;
  logic             sweep_dir_q;

  step_job_t job_x, job_y, pan_job;
  logic      moving, pan_load, tilt_load;
  logic      pan_done, pan_busy, tilt_busy, tilt_done;
  logic      at_pos_lim, at_neg_lim;

  assign job_x  = calc_job(aim_x, CENTER_X, DEADBAND, GAIN_SHIFT, MAX_STEPS);
  assign job_y  = calc_job(aim_y, CENTER_Y, DEADBAND, GAIN_SHIFT, MAX_STEPS);
  assign moving = (job_x.count != '0) || (job_y.count != '0);

  assign at_pos_lim = $signed(pan_pos) >= PanLimPos;
  assign at_neg_lim = $signed(pan_pos) <= PanLimNeg;

  // Job loads are combinational from frame_tick so they land on the tick edge.
  always_comb begin
    pan_load  = 1'b0;
    tilt_load = 1'b0;
    pan_job   = job_x;
    if (frame_tick) begin
      unique case (state_q)
        StIdle: begin
          pan_load  = aim_detected;
          tilt_load = aim_detected;
        end
        StTrack: begin
          pan_load  = aim_detected && !target_off;
          tilt_load = aim_detected && !target_off;
        end
        StLocked: begin
          pan_load  = aim_detected && !target_off && moving;
          tilt_load = aim_detected && !target_off && moving;
        end
        StSearch: begin
          if (aim_detected) begin
            pan_load  = 1'b1;
            tilt_load = 1'b1;
          end else begin
            pan_load      = 1'b1;
            pan_job.count = StepW'(MAX_STEPS);
            pan_job.dir   = sweep_dir_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      lock_cnt_q <= '0;
      laser_en   <= 1'b0;
    end else begin
      laser_en <= (state_q == StLocked) && raser_shoot;
      if (frame_tick) begin
        unique case (state_q)
          StIdle: begin
            state_q    <= aim_detected ? StTrack : StSearch;
            lock_cnt_q <= '0;
          end
          StTrack: begin
            if (target_off) begin
              state_q    <= StSearch;
              lock_cnt_q <= '0;
            end else if (aim_detected) begin
              if (moving) begin
                lock_cnt_q <= '0;
              end else if (lock_cnt_q == LockLast) begin
                state_q    <= StLocked;
                lock_cnt_q <= '0;
              end else begin
                lock_cnt_q <= lock_cnt_q + LockW'(1);
              end
            end
          end
          StLocked: begin
            if (target_off) begin
              state_q <= StSearch;
            end else if (aim_detected && moving) begin
              state_q    <= StTrack;
              lock_cnt_q <= '0;
            end
          end
          StSearch: begin
            if (aim_detected) begin
              state_q    <= StTrack;
              lock_cnt_q <= '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pan_pos     <= '0;
      sweep_dir_q <= 1'b1;
    end else begin
      if (pan_done) pan_pos <= pan_dir ? pan_pos + 12'd1 : pan_pos - 12'd1;
      if (at_pos_lim) begin
        sweep_dir_q <= 1'b0;
      end else if (at_neg_lim) begin
        sweep_dir_q <= 1'b1;
      end
    end
  end

  step_pulse_gen #(
    .STEP_HALF (STEP_HALF)
  ) u_pan (
    .clk        (clk),
    .reset      (reset),
    .load       (pan_load),
    .load_count (pan_job.count),
    .load_dir   (pan_job.dir),
    .block_pos  (at_pos_lim),
    .block_neg  (at_neg_lim),
    .step       (pan_step),
    .dir        (pan_dir),
    .busy       (pan_busy),
    .step_done  (pan_done)
  );

  step_pulse_gen #(
    .STEP_HALF (STEP_HALF)
  ) u_tilt (
    .clk        (clk),
    .reset      (reset),
    .load       (tilt_load),
    .load_count (job_y.count),
    .load_dir   (job_y.dir),
    .block_pos  (1'b0),
    .block_neg  (1'b0),
    .step       (tilt_step),
    .dir        (tilt_dir),
    .busy       (tilt_busy),
    .step_done  (tilt_done)
  );

  // Busy/done flags not needed at this level.
  logic unused_flags;
  assign unused_flags = ^{pan_busy, tilt_busy, tilt_done};

  assign state_o = state_q;

endmodule
